fpu_mc_unit: RTL and testbench

- Multi-cycle, handshaked successor to the single-cycle combinational FPU select stage.
- Captures operands, op code and tag on a valid/ready handshake into input registers.
- Feeds the registered operands to the team's combinational add/sub, multiply, divide and square-root units.
- Waits a per-op parameterised latency so those datapaths can be constrained as multicycle paths, then registers and holds the result until the consumer accepts it.
- Sits between the integer pipeline's FP issue point and FP register-file writeback.

---
 rtl/fpu_mc_unit.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_fpu_mc_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mc_unit.sv
// Multi-cycle handshaked FPU: registered operands, per-op EXEC latency, held result.
// Optional exception flags (out_flags, flags_sticky, flags_clr) with `define FPU_FLAGS_EN.
module fpu_mc_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned TAG_W    = 5,
    parameter int unsigned ADD_LAT  = 1,
    parameter int unsigned MUL_LAT  = 2,
    parameter int unsigned DIV_LAT  = 4,
    parameter int unsigned SQRT_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic [WIDTH-1:0] in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
`ifdef FPU_FLAGS_EN
    ,
    output logic [4:0]       out_flags,
    output logic [4:0]       flags_sticky,
    input  logic             flags_clr
`endif
);

    localparam logic [31:0] QNAN = 32'h7FC00000;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    // Subnormal inputs are treated as zero.
    function automatic logic is_zero(input logic [31:0] x);
        return x[30:23] == 8'd0;
    endfunction

    function automatic logic [31:0] pack(input logic s, input int e, input logic [22:0] f);
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), f};
    endfunction

    // Truncating add; b already carries the effective (sub-adjusted) sign.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [26:0] mx, my;
        logic [27:0] s;
        logic [7:0]  d;
        int          e;
        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && (a[31] != b[31]))) return QNAN;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        if (is_zero(a) && is_zero(b)) return {a[31] & b[31], 31'd0};
        if (is_zero(b)) return a;
        if (is_zero(a)) return b;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d  = x[30:23] - y[30:23];
        mx = {1'b1, x[22:0], 3'b000};
        my = (d > 8'd26) ? 27'd0 : ({1'b1, y[22:0], 3'b000} >> d);
        e  = int'(x[30:23]);
        if (x[31] == y[31]) begin
            s = {1'b0, mx} + {1'b0, my};
            if (s[27]) begin
                s = s >> 1;
                e = e + 1;
            end
        end else begin
            s = {1'b0, mx} - {1'b0, my};
            if (s == 28'd0) return 32'd0;
            for (int i = 0; i < 26; i++) begin
                if (!s[26]) begin
                    s = s << 1;
                    e = e - 1;
                end
            end
        end
        return pack(x[31], e, 23'(s >> 3));
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic        s;
        int          e;
        s = a[31] ^ b[31];
        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b)))
            return QNAN;
        if (is_inf(a) || is_inf(b)) return {s, 8'hFF, 23'd0};
        if (is_zero(a) || is_zero(b)) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) return pack(s, e + 1, 23'(p >> 24));
        return pack(s, e, 23'(p >> 23));
    endfunction

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] q;
        logic        s;
        int          e;
        s = a[31] ^ b[31];
        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b)) || (is_zero(a) && is_zero(b)))
            return QNAN;
        if (is_inf(a) || is_zero(b)) return {s, 8'hFF, 23'd0};
        if (is_zero(a) || is_inf(b)) return {s, 31'd0};
        q = {1'b1, a[22:0], 24'd0} / {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q[24]) return pack(s, e, 23'(q >> 1));
        return pack(s, e - 1, 23'(q));
    endfunction

    function automatic logic [23:0] isqrt(input logic [47:0] x);
        logic [26:0] rem;
        logic [26:0] trial;
        logic [23:0] root;
        rem  = '0;
        root = '0;
        for (int i = 23; i >= 0; i--) begin
            rem   = {rem[24:0], x[2*i+1 -: 2]};
            trial = {1'b0, root, 2'b01};
            if (rem >= trial) begin
                rem  = rem - trial;
                root = {root[22:0], 1'b1};
            end else begin
                root = {root[22:0], 1'b0};
            end
        end
        return root;
    endfunction

    function automatic logic [31:0] fsqrt(input logic [31:0] a);
        logic [47:0] r;
        logic [23:0] m;
        int          e;
        if (is_nan(a) || (a[31] && !is_zero(a))) return QNAN;
        if (is_zero(a)) return {a[31], 31'd0};
        if (is_inf(a)) return a;
        m = {1'b1, a[22:0]};
        // Odd biased exponent means even unbiased exponent: no extra radicand shift.
        if (a[23]) begin
            r = {1'b0, m, 23'd0};
            e = (int'(a[30:23]) + 127) / 2;
        end else begin
            r = {m, 24'd0};
            e = (int'(a[30:23]) + 126) / 2;
        end
        return pack(1'b0, e, 23'(isqrt(r)));
    endfunction

    function automatic logic [7:0] lat_cnt(input logic [1:0] op);
        case (op)
            2'b00:   return 8'(ADD_LAT - 1);
            2'b01:   return 8'(MUL_LAT - 1);
            2'b10:   return 8'(DIV_LAT - 1);
            default: return 8'(SQRT_LAT - 1);
        endcase
    endfunction

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [1:0]         op_q;
    logic               sub_q;
    logic [WIDTH-1:0]   rs1_q, rs2_q, res_q, unit_res;
    logic [TAG_W-1:0]   tag_q, out_tag_q;
    logic               accept, capture;

    assign in_ready   = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign out_valid  = (state_q == StDone);
    assign out_result = res_q;
    assign out_tag    = out_tag_q;

    always_comb begin
        unit_res = '0;
        unique case (op_q)
            2'b00: unit_res = fadd(rs1_q, {rs2_q[31] ^ sub_q, rs2_q[30:0]});
            2'b01: unit_res = fmul(rs1_q, rs2_q);
            2'b10: unit_res = fdiv(rs1_q, rs2_q);
            2'b11: unit_res = fsqrt(rs1_q);
            default: unit_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        capture = 1'b0;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        accept  = 1'b1;
                        state_d = StExec;
                        cnt_d   = lat_cnt(in_op);
                    end
                end
                StExec: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        capture = 1'b1;
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            accept  = 1'b1;
                            state_d = StExec;
                            cnt_d   = lat_cnt(in_op);
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= '0;
            sub_q     <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            tag_q     <= '0;
            res_q     <= '0;
            out_tag_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q  <= in_op;
                sub_q <= in_sub;
                rs1_q <= in_rs1;
                rs2_q <= in_rs2;
                tag_q <= in_tag;
            end
            if (capture) begin
                res_q     <= unit_res;
                out_tag_q <= tag_q;
            end
        end
    end

`ifdef FPU_FLAGS_EN
    logic [4:0] flags_d, flags_q, sticky_q;
    logic       a_fin, b_fin, a_nz, b_nz, f_nv, f_dz, f_of, f_uf;

    // Sqrt has no second operand; treat it as finite and non-zero.
    always_comb begin
        a_fin   = rs1_q[30:23] != 8'hFF;
        b_fin   = (op_q == 2'b11) || (rs2_q[30:23] != 8'hFF);
        a_nz    = !is_zero(rs1_q);
        b_nz    = (op_q == 2'b11) || !is_zero(rs2_q);
        f_nv    = is_nan(unit_res) || ((op_q == 2'b11) && rs1_q[31] && a_nz);
        f_dz    = (op_q == 2'b10) && !b_nz && a_fin && a_nz;
        f_of    = is_inf(unit_res) && a_fin && b_fin && !f_dz;
        f_uf    = ((unit_res[30:23] == 8'd0) && (unit_res[22:0] != 23'd0)) ||
                  ((unit_res[30:0] == 31'd0) && a_nz && b_nz && a_fin && b_fin);
        flags_d = {f_nv, f_dz, f_of, f_uf, 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q  <= '0;
            sticky_q <= '0;
        end else begin
            if (capture) flags_q <= flags_d;
            if (flags_clr) sticky_q <= '0;
            else if (out_valid && out_ready) sticky_q <= sticky_q | flags_q;
        end
    end

    assign out_flags    = flags_q;
    assign flags_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_fpu_mc_unit.sv
// Scoreboard bench for fpu_mc_unit: directed vectors, monitor pops expected results on handshake.
module tb_fpu_mc_unit;

    logic        clk, rst;
    logic        in_valid, in_ready, in_sub, flush, out_valid, out_ready;
    logic [1:0]  in_op;
    logic [31:0] in_rs1, in_rs2, out_result;
    logic [4:0]  in_tag, out_tag;
`ifdef FPU_FLAGS_EN
    logic [4:0]  out_flags, flags_sticky;
    logic        flags_clr;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
        logic [4:0]  flg;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    fpu_mc_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_sub     (in_sub),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
`ifdef FPU_FLAGS_EN
        ,
        .out_flags   (out_flags),
        .flags_sticky(flags_sticky),
        .flags_clr   (flags_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic sub, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic push,
                        input logic [31:0] res, input logic [4:0] flg);
        int n = 0;
        in_op    = op;
        in_sub   = sub;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 for tag %0d", tag);
        end
        if (push) sb.push_back({res, tag, flg});
        tick();
        // Scramble inputs after acceptance: the latched request must be unaffected.
        in_valid = 1'b0;
        in_op    = 2'($urandom);
        in_sub   = 1'($urandom);
        in_rs1   = $urandom;
        in_rs2   = $urandom;
        in_tag   = 5'($urandom);
    endtask

    task automatic wait_out(input string name, input int exp_lat);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk(name, lat, exp_lat);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %h tag %0d want none", out_result, out_tag);
            end else begin
                mon_e = sb.pop_front();
                chk("result", out_result, mon_e.res);
                chk("tag", {27'd0, out_tag}, {27'd0, mon_e.tag});
`ifdef FPU_FLAGS_EN
                chk("flags", {27'd0, out_flags}, {27'd0, mon_e.flg});
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_sub    = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
`ifdef FPU_FLAGS_EN
        flags_clr = 1'b0;
`endif
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
`ifdef FPU_FLAGS_EN
        chk("rst_flags", out_flags, 0);
        chk("rst_sticky", flags_sticky, 0);
`endif
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // 1.0 + 2.0 = 3.0
        send(2'b00, 1'b0, 32'h3F800000, 32'h40000000, 5'd3, 1'b1, 32'h40400000, 5'd0);
        chk("add_exec_in_ready", in_ready, 0);
        chk("add_exec_out_valid", out_valid, 0);
        wait_out("add_lat", 1);
        tick();

        // 6.0 / 2.0 = 3.0 with back-pressure
        out_ready = 1'b0;
        send(2'b10, 1'b0, 32'h40C00000, 32'h40000000, 5'd7, 1'b1, 32'h40400000, 5'd0);
        chk("div_exec_in_ready", in_ready, 0);
        wait_out("div_lat", 4);
        for (int i = 0; i < 5; i++) begin
            chk("div_hold_valid", out_valid, 1);
            chk("div_hold_result", out_result, 32'h40400000);
            chk("div_hold_in_ready", in_ready, 0);
            tick();
        end

        // Same-edge consume and accept: 2.0 * 3.0 = 6.0
        out_ready = 1'b1;
        #0;
        chk("done_in_ready", in_ready, 1);
        send(2'b01, 1'b0, 32'h40000000, 32'h40400000, 5'd9, 1'b1, 32'h40C00000, 5'd0);
        chk("mul_exec_out_valid", out_valid, 0);
        wait_out("mul_lat", 2);
        tick();

        // sqrt(9.0) flushed on second EXEC cycle
        send(2'b11, 1'b0, 32'h41100000, 32'h0, 5'd1, 1'b0, 32'h0, 5'd0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            chk("flush_no_valid", out_valid, 0);
            tick();
        end

        // Request coinciding with flush in IDLE is not accepted
        in_op    = 2'b00;
        in_rs1   = 32'h3F800000;
        in_rs2   = 32'h3F800000;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_blocks_accept", in_ready, 1);
        tick();
        chk("flush_blocks_result", out_valid, 0);

        // 3.0 - 1.0 = 2.0, 1.0 - 3.0 = -2.0, 1.5 * 1.5 = 2.25
        send(2'b00, 1'b1, 32'h40400000, 32'h3F800000, 5'd4, 1'b1, 32'h40000000, 5'd0);
        wait_out("sub_lat", 1);
        tick();
        send(2'b00, 1'b1, 32'h3F800000, 32'h40400000, 5'd5, 1'b1, 32'hC0000000, 5'd0);
        wait_out("sub_neg_lat", 1);
        tick();
        send(2'b01, 1'b0, 32'h3FC00000, 32'h3FC00000, 5'd6, 1'b1, 32'h40100000, 5'd0);
        wait_out("mul2_lat", 2);
        tick();

        // Asynchronous reset mid-EXEC
        send(2'b10, 1'b0, 32'h40C00000, 32'h40000000, 5'd11, 1'b0, 32'h0, 5'd0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_result", out_result, 0);
        chk("arst_out_tag", out_tag, 0);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("arst_op_lost", out_valid, 0);
        end

        // 1.0 / 0.0 = +inf, DZ
        send(2'b10, 1'b0, 32'h3F800000, 32'h00000000, 5'd2, 1'b1, 32'h7F800000, 5'b01000);
        wait_out("dz_lat", 4);
        tick();
`ifdef FPU_FLAGS_EN
        chk("sticky_dz", flags_sticky, 5'b01000);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        chk("sticky_clr", flags_sticky, 0);
`endif

        // sqrt(9.0) = 3.0
        send(2'b11, 1'b0, 32'h41100000, 32'h12345678, 5'd8, 1'b1, 32'h40400000, 5'd0);
        wait_out("sqrt_lat", 4);
        tick();

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d results missing, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
